// File: rtl/rfphoenix_trace_queue_pkg.sv
// Shared types for the branch-trace queue that feeds the execute-stage ALU.
// Overwrite-on-full is enabled by defining RFPHOENIX_TRACE_OVERWRITE_EN.
package rfPhoenixPkg;

    localparam int ADDR_W = 32;

    typedef logic [ADDR_W-1:0] Address;
    typedef logic [10:0]       trace_count_t;

    localparam logic [3:0] TRACE_QNUM = 4'd15;

endpackage

// File: rtl/rfphoenix_trace_ram.sv
// Simple dual-port trace storage: synchronous write, asynchronous read.
// Build option RFPHOENIX_TRACE_OVERWRITE_EN does not affect this module.
module rfphoenix_trace_ram
    import rfPhoenixPkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int W     = ADDR_W
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rfphoenix_trace_queue.sv
// Branch-trace FIFO with a first-word-fall-through head register.
// Define RFPHOENIX_TRACE_OVERWRITE_EN to evict the oldest entry on full.
module rfphoenix_trace_queue
    import rfPhoenixPkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              tron,
    input  logic              push,
    input  logic [ADDR_W-1:0] adr,
    input  logic              pop,
    input  logic              clear,
    output logic [ADDR_W-1:0] trace_dout,
    output logic              trace_empty,
    output logic              trace_valid,
    output logic [10:0]       trace_count,
    output logic              trace_full,
    output logic              trace_ovf
);

    localparam trace_count_t DEPTH_C = trace_count_t'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    trace_count_t      count_q, count_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W-1:0] dout_q, dout_d;

    logic              full;
    logic              pop_acc;
    logic              drop;
    logic              push_ok;
    logic              evict;
    logic              adv;
    logic              skip;
    logic              prefetch;
    logic              we;
    trace_count_t      mem_cnt;
    logic [ADDR_W-1:0] rdata;

    assign full    = (count_q == DEPTH_C);
    assign pop_acc = pop & valid_q;
    // A push on full with no pop to make room either loses data or evicts.
    assign drop    = push & tron & full & ~pop_acc;

`ifdef RFPHOENIX_TRACE_OVERWRITE_EN
    assign push_ok = push & tron;
    assign evict   = drop;
`else
    assign push_ok = push & tron & ~drop;
    assign evict   = 1'b0;
`endif

    // Entries sitting in the array, all written on earlier edges.
    assign mem_cnt  = count_q - trace_count_t'(valid_q);
    assign adv      = pop_acc | (evict & valid_q);
    assign skip     = evict & ~valid_q;
    assign prefetch = (~valid_q | adv) & (mem_cnt != '0) & ~skip;
    assign we       = push_ok & ~clear;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        dout_d  = dout_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            if (push_ok) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (prefetch) begin
                dout_d  = rdata;
                rptr_d  = rptr_q + PTR_ONE;
                valid_d = 1'b1;
            end else if (adv) begin
                valid_d = 1'b0;
            end
            if (skip) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            if (push_ok && !(pop_acc || evict)) begin
                count_d = count_q + 11'd1;
            end else if (!push_ok && pop_acc) begin
                count_d = count_q - 11'd1;
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            dout_q  <= dout_d;
        end
    end

    rfphoenix_trace_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (wptr_q),
        .wdata_i (adr),
        .raddr_i (rptr_q),
        .rdata_o (rdata)
    );

    assign trace_dout  = dout_q;
    assign trace_empty = (count_q == '0);
    assign trace_valid = valid_q;
    assign trace_count = count_q;
    assign trace_full  = full;
    assign trace_ovf   = ovf_q;

endmodule

// File: tb/tb_rfphoenix_trace_queue.sv
// Bench for the trace queue: queue-based reference plus literal spot checks.
// Build with RFPHOENIX_TRACE_OVERWRITE_EN defined to exercise eviction.
module tb_rfphoenix_trace_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tron = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] adr = '0;

    logic [31:0] trace_dout;
    logic        trace_empty;
    logic        trace_valid;
    logic [10:0] trace_count;
    logic        trace_full;
    logic        trace_ovf;

    rfphoenix_trace_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .rst         (rst),
        .clk         (clk),
        .tron        (tron),
        .push        (push),
        .adr         (adr),
        .pop         (pop),
        .clear       (clear),
        .trace_dout  (trace_dout),
        .trace_empty (trace_empty),
        .trace_valid (trace_valid),
        .trace_count (trace_count),
        .trace_full  (trace_full),
        .trace_ovf   (trace_ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: every held entry in order, head first.
    logic [31:0] mq[$];
    logic        m_valid = 1'b0;
    logic        m_ovf = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Head is visible once it was already queued before the latest edge.
    task automatic model_edge();
        bit pa;
        int n_new;
        pa = pop && m_valid;
        n_new = 0;
        if (clear) begin
            mq.delete();
            m_valid = 1'b0;
            m_ovf = 1'b0;
        end else begin
            if (pa) void'(mq.pop_front());
            if (push && tron) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(adr);
                    n_new = 1;
                end else begin
                    m_ovf = 1'b1;
`ifdef RFPHOENIX_TRACE_OVERWRITE_EN
                    void'(mq.pop_front());
                    mq.push_back(adr);
                    n_new = 1;
`endif
                end
            end
            m_valid = (mq.size() > n_new);
        end
    endtask

    always @(negedge clk) begin
        chk("count", 32'(trace_count), 32'(mq.size()));
        chk("empty", 32'(trace_empty), 32'(mq.size() == 0));
        chk("full", 32'(trace_full), 32'(mq.size() == DEPTH));
        chk("valid", 32'(trace_valid), 32'(m_valid));
        chk("ovf", 32'(trace_ovf), 32'(m_ovf));
        if (m_valid) chk("dout", trace_dout, mq[0]);
    end

    task automatic step(input bit ps, input logic [31:0] a,
                        input bit pp, input bit cl);
        push = ps;
        adr = a;
        pop = pp;
        clear = cl;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        push = 1'b0;
        pop = 1'b0;
        clear = 1'b0;
    endtask

    logic [31:0] exp_full [4];

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dout", trace_dout, 32'h0);
        chk("rst_empty", 32'(trace_empty), 32'd1);
        chk("rst_valid", 32'(trace_valid), 32'd0);
        chk("rst_count", 32'(trace_count), 32'd0);
        chk("rst_full", 32'(trace_full), 32'd0);
        chk("rst_ovf", 32'(trace_ovf), 32'd0);
        rst = 1'b0;
        repeat (20) step(0, 32'h0, 0, 0);
        chk("idle_count", 32'(trace_count), 32'd0);
        chk("idle_dout", trace_dout, 32'h0);

        // Basic ordering and first-word latency
        tron = 1'b1;
        step(1, 32'h1000, 0, 0);
        chk("fwft_empty", 32'(trace_empty), 32'd0);
        chk("fwft_valid0", 32'(trace_valid), 32'd0);
        step(1, 32'h2000, 0, 0);
        chk("fwft_valid1", 32'(trace_valid), 32'd1);
        step(1, 32'h3000, 0, 0);
        chk("basic_count", 32'(trace_count), 32'd3);
        chk("basic_head", trace_dout, 32'h1000);
        step(0, 32'h0, 1, 0);
        chk("pop1", trace_dout, 32'h2000);
        step(0, 32'h0, 1, 0);
        chk("pop2", trace_dout, 32'h3000);
        step(0, 32'h0, 1, 0);
        chk("drain_empty", 32'(trace_empty), 32'd1);
        chk("drain_valid", 32'(trace_valid), 32'd0);

        // Gated push and pop with nothing valid
        tron = 1'b0;
        step(1, 32'hDEAD, 0, 0);
        chk("gate_count", 32'(trace_count), 32'd0);
        step(0, 32'h0, 1, 0);
        chk("badpop_count", 32'(trace_count), 32'd0);
        tron = 1'b1;

        // Push and pop together with a single entry
        step(1, 32'hA0, 0, 0);
        step(0, 32'h0, 0, 0);
        chk("pp_head", trace_dout, 32'hA0);
        step(1, 32'hB0, 1, 0);
        chk("pp_count", 32'(trace_count), 32'd1);
        chk("pp_valid0", 32'(trace_valid), 32'd0);
        step(0, 32'h0, 0, 0);
        chk("pp_valid1", 32'(trace_valid), 32'd1);
        chk("pp_dout", trace_dout, 32'hB0);
        step(0, 32'h0, 1, 0);

        // Full and overflow
        for (int i = 1; i <= 5; i++) step(1, 32'(i), 0, 0);
        chk("full_count", 32'(trace_count), 32'd4);
        chk("full_flag", 32'(trace_full), 32'd1);
        chk("full_ovf", 32'(trace_ovf), 32'd1);
`ifdef RFPHOENIX_TRACE_OVERWRITE_EN
        exp_full = '{32'd2, 32'd3, 32'd4, 32'd5};
`else
        exp_full = '{32'd1, 32'd2, 32'd3, 32'd4};
`endif
        for (int i = 0; i < 4; i++) begin
            chk("full_pop", trace_dout, exp_full[i]);
            step(0, 32'h0, 1, 0);
        end
        chk("full_drained", 32'(trace_empty), 32'd1);

        // Clear beats push and pop
        step(1, 32'h11, 0, 0);
        step(1, 32'h22, 0, 0);
        step(1, 32'h33, 0, 0);
        chk("clr_pre", 32'(trace_count), 32'd3);
        step(1, 32'h77, 1, 1);
        chk("clr_count", 32'(trace_count), 32'd0);
        chk("clr_empty", 32'(trace_empty), 32'd1);
        chk("clr_valid", 32'(trace_valid), 32'd0);
        chk("clr_ovf", 32'(trace_ovf), 32'd0);
        step(1, 32'h88, 0, 0);
        step(0, 32'h0, 0, 0);
        chk("clr_after", trace_dout, 32'h88);
        step(0, 32'h0, 1, 0);

        // Pointer wrap over three fill/drain rounds
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 4; k++) step(1, 32'(c * 16 + k), 0, 0);
            chk("wrap_full", 32'(trace_full), 32'd1);
            for (int k = 0; k < 4; k++) begin
                chk("wrap_dout", trace_dout, 32'(c * 16 + k));
                step(0, 32'h0, 1, 0);
            end
        end

        // Push with pop while full is accepted
        for (int k = 0; k < 4; k++) step(1, 32'(32'h50 + k), 0, 0);
        step(1, 32'h99, 1, 0);
        chk("fpp_count", 32'(trace_count), 32'd4);
        chk("fpp_head", trace_dout, 32'h51);
        chk("fpp_ovf", 32'(trace_ovf), 32'd0);
        repeat (4) step(0, 32'h0, 1, 0);
        chk("fpp_empty", 32'(trace_empty), 32'd1);

        // tron drop mid-stream keeps queued entries
        step(1, 32'hC1, 0, 0);
        step(1, 32'hC2, 0, 0);
        tron = 1'b0;
        step(1, 32'hC3, 0, 0);
        chk("tron_count", 32'(trace_count), 32'd2);
        step(0, 32'h0, 1, 0);
        chk("tron_pop", trace_dout, 32'hC2);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
